wash_sequencer: RTL
===================

# wash_sequencer

Program sequencer for the washing-machine controller: it latches a wash mode on a start pulse and steps through the wash, rinse and spin phases on a 1 s tick. For each second it issues one actuator action code (rotate, stew, fill, drain, forward spin, reverse spin) and maintains the remaining-seconds count for the 7-segment display. It sits between the debounced button/switch inputs and the display/status-light logic, and replaces the hard-wired phase timing in the top level.

## Interface
- TICK_DIV, 100_000_000: clk cycles per 1 s tick.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  power switch; low forces IDLE synchronously.
- start_p  in  1  single-cycle pulse from the debounced button: start, resume, or acknowledge.
- pause_p  in  1  single-cycle pause pulse.
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large; sampled only in IDLE.
- door_closed  in  1  interlock, high = closed.
- phase  out  2  00 setup, 01 wash, 10 rinse, 11 spin; drives the status lights.
- act  out  3  actuator code: 0 ROTATE, 1 STEW, 2 FILL, 3 DRAIN, 4 FSPIN, 5 RSPIN, 7 IDLE.
- remain  out  7  seconds left, 0..99.
- running  out  1  high in RUN only.
- done  out  1  high in DONE.
- buzz  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Phase durations per mode (wash/rinse/spin, in s):
  - 00: –/–/20, total 20
  - 01: 20/20/20, total 60
  - 10: 30/20/20, total 70
  - 11: 40/30/20, total 90
- IDLE:
  - phase=00, act=IDLE, remain tracks total(mode) with 1-cycle lag.
  - start_p with door_closed=1 → latch mode, load remain=total, clear the second counter, enter RUN. Phase is 11 for mode 00, otherwise 01.
  - start_p with the door open is ignored.
- RUN: each tick decrements remain and increments the in-phase second counter s.
  - When s reaches the phase duration: s←0, go to the next phase (01→10→11).
  - End of spin → DONE.
- Action per in-phase second s:
  - wash: s<4 FILL; otherwise (s−4) mod 3 <2 ROTATE, else STEW.
  - rinse: s<4 DRAIN; 4≤s<8 FILL; else ROTATE.
  - spin: s<4 DRAIN; otherwise (s−4) mod 6 <3 FSPIN, else RSPIN.
- RUN→HOLD on pause_p or door_closed=0. In HOLD:
  - act=IDLE; phase, remain, s and the prescaler count are all frozen (not cleared).
- HOLD→RUN on start_p or pause_p, only with door_closed=1.
- DONE: remain=0, act=IDLE, done=1, phase=11. start_p → IDLE.
- Simultaneous events:
  - In RUN, pause_p together with start_p → HOLD.
  - In RUN, door opening on the same cycle as a tick → the tick is applied, then HOLD.
  - In IDLE, pause_p is ignored.
- en=0 in any state → IDLE on the next edge, with all counters cleared. Inputs are ignored while en=0.

## Timing
- Reset values: state IDLE, phase 00, act 7, remain 0, running 0, done 0, buzz 0, latched mode 01, prescaler 0.
- All outputs are registered. An event in cycle N (tick, pulse, door change) is visible from cycle N+1.
- Tick:
  - The prescaler counts 0..TICK_DIV−1 only in RUN.
  - The tick fires in the cycle the count equals TICK_DIV−1; the count wraps to 0.
  - The first tick comes TICK_DIV cycles after entering RUN.
- remain never underflows. The final tick sets remain=0 and enters DONE in the same update; buzz is high for exactly that one cycle.
- s is 6 bits; the pattern sub-counters are 3 bits, cleared on every phase change.

## Structure
- wash_pkg holds:
  - state enum
  - phase codes and action codes
  - the per-mode duration constants, and a function total(mode)
- Sub-module sec_tick: prescaler with enable, parameter TICK_DIV, output tick. It holds its count when disabled and clears on en=0.
- Top-level wash instantiates wash_sequencer, feeding it the button pulse and driving the display and lights from phase/remain.

## Test plan
All scenarios run with TICK_DIV=4.
- Reset: assert rst=0 mid-run → phase=00, act=7, remain=0, running=0, done=0 immediately; these hold after release.
- Mode 01 start:
  - remain=60; act sequence FILL×4, ROTATE, ROTATE, STEW…
  - After tick 20: phase=10, act=DRAIN, remain=40.
  - After tick 60: DONE, done=1, buzz high for 1 cycle, act=7.
- Mode 00 start: phase=11 directly, remain=20, act=DRAIN for 4 ticks then FSPIN×3 / RSPIN×3; DONE after 20 ticks (80 cycles).
- Pause at remain=50:
  - act=7; remain and prescaler frozen for 37 cycles.
  - pause_p resumes; DONE occurs exactly 37 cycles later than an uninterrupted run.
- Door interlock:
  - Door opens in RUN → HOLD.
  - start_p while the door is open → stays in HOLD.
  - Door closes, then start_p → RUN continues from the same remain and act.
- en dropped during rinse → IDLE next cycle. Re-enable with mode=11 → remain=90 after 1 cycle; start_p → wash for 40 s.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types, codes and program timing for the wash sequencer.
// Durations live here so the top-level timing tables stay in one place.
package wash_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE} state_t;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_WASH  = 2'd1;
    localparam logic [1:0] PH_RINSE = 2'd2;
    localparam logic [1:0] PH_SPIN  = 2'd3;

    localparam logic [2:0] ACT_ROTATE = 3'd0;
    localparam logic [2:0] ACT_STEW   = 3'd1;
    localparam logic [2:0] ACT_FILL   = 3'd2;
    localparam logic [2:0] ACT_DRAIN  = 3'd3;
    localparam logic [2:0] ACT_FSPIN  = 3'd4;
    localparam logic [2:0] ACT_RSPIN  = 3'd5;
    localparam logic [2:0] ACT_IDLE   = 3'd7;

    localparam logic [5:0] SPIN_S = 6'd20;

    // Mode 00 has no wash or rinse, so those durations are zero.
    function automatic logic [5:0] phase_dur(input logic [1:0] m, input logic [1:0] ph);
        logic [5:0] d;
        d = 6'd0;
        case (ph)
            PH_WASH:  case (m)
                          2'd1:    d = 6'd20;
                          2'd2:    d = 6'd30;
                          2'd3:    d = 6'd40;
                          default: d = 6'd0;
                      endcase
            PH_RINSE: case (m)
                          2'd1, 2'd2: d = 6'd20;
                          2'd3:       d = 6'd30;
                          default:    d = 6'd0;
                      endcase
            PH_SPIN:  d = SPIN_S;
            default:  d = 6'd0;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] total(input logic [1:0] m);
        return {1'b0, phase_dur(m, PH_WASH)} + {1'b0, phase_dur(m, PH_RINSE)} + {1'b0, SPIN_S};
    endfunction

    // p is the pattern sub-counter: (s-4) mod 3 in wash, (s-4) mod 6 in spin.
    function automatic logic [2:0] act_of(input logic [1:0] ph, input logic [5:0] s, input logic [2:0] p);
        logic [2:0] a;
        a = ACT_IDLE;
        case (ph)
            PH_WASH:  a = (s < 6'd4) ? ACT_FILL  : ((p < 3'd2) ? ACT_ROTATE : ACT_STEW);
            PH_RINSE: a = (s < 6'd4) ? ACT_DRAIN : ((s < 6'd8) ? ACT_FILL : ACT_ROTATE);
            PH_SPIN:  a = (s < 6'd4) ? ACT_DRAIN : ((p < 3'd3) ? ACT_FSPIN : ACT_RSPIN);
            default:  a = ACT_IDLE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Button/switch inputs and display/light outputs of the wash sequencer.
interface wash_sequencer_if;
    logic       en;
    logic       start_p;
    logic       pause_p;
    logic [1:0] mode;
    logic       door_closed;
    logic [1:0] phase;
    logic [2:0] act;
    logic [6:0] remain;
    logic       running;
    logic       done;
    logic       buzz;

    modport master (output en, start_p, pause_p, mode, door_closed,
                    input  phase, act, remain, running, done, buzz);
    modport slave  (input  en, start_p, pause_p, mode, door_closed,
                    output phase, act, remain, running, done, buzz);
endinterface

// File: rtl/sec_tick.sv
// One-second prescaler: counts only while cnt_en, holds otherwise, clears when power is off.
module sec_tick #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic cnt_en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && cnt_en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt <= '0;
        else if (!en)    cnt <= '0;
        else if (cnt_en) cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/wash_sequencer.sv
// Wash program sequencer: latches mode on start, walks wash/rinse/spin on the 1 s tick
// and emits one actuator code per second plus the remaining-seconds count.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input logic             clk,
    input logic             rst,
    wash_sequencer_if.slave bus
);
    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] act_q, act_d;
    logic [6:0] remain_q, remain_d;
    logic [5:0] s_q, s_d;
    logic [2:0] pat_q, pat_d;
    logic [1:0] mode_q, mode_d;
    logic       running_q, done_q, buzz_q, buzz_d;
    logic       tick;
    logic [2:0] pat_last;

    sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .cnt_en (state_q == ST_RUN),
        .tick   (tick)
    );

    assign pat_last = (phase_q == PH_WASH) ? 3'd2 : 3'd5;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_SETUP;
            act_q     <= ACT_IDLE;
            remain_q  <= 7'd0;
            s_q       <= 6'd0;
            pat_q     <= 3'd0;
            mode_q    <= 2'd1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            act_q     <= act_d;
            remain_q  <= remain_d;
            s_q       <= s_d;
            pat_q     <= pat_d;
            mode_q    <= mode_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            buzz_q    <= buzz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        act_d    = act_q;
        remain_d = remain_q;
        s_d      = s_q;
        pat_d    = pat_q;
        mode_d   = mode_q;
        buzz_d   = 1'b0;
        if (!bus.en) begin
            state_d  = ST_IDLE;
            phase_d  = PH_SETUP;
            act_d    = ACT_IDLE;
            remain_d = 7'd0;
            s_d      = 6'd0;
            pat_d    = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d  = PH_SETUP;
                    act_d    = ACT_IDLE;
                    remain_d = total(bus.mode);
                    if (bus.start_p && bus.door_closed) begin
                        mode_d  = bus.mode;
                        s_d     = 6'd0;
                        pat_d   = 3'd0;
                        phase_d = (bus.mode == 2'd0) ? PH_SPIN : PH_WASH;
                        act_d   = act_of(phase_d, 6'd0, 3'd0);
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (remain_q != 7'd0) remain_d = remain_q - 7'd1;
                        if (s_q + 6'd1 == phase_dur(mode_q, phase_q)) begin
                            s_d   = 6'd0;
                            pat_d = 3'd0;
                            if (phase_q == PH_SPIN) begin
                                state_d  = ST_DONE;
                                remain_d = 7'd0;
                                buzz_d   = 1'b1;
                            end else begin
                                phase_d = phase_q + 2'd1;
                            end
                        end else begin
                            s_d   = s_q + 6'd1;
                            pat_d = (s_q < 6'd4 || pat_q == pat_last) ? 3'd0 : pat_q + 3'd1;
                        end
                    end
                    act_d = act_of(phase_d, s_d, pat_d);
                    // A finishing tick wins over a pause or door event in the same cycle.
                    if (state_d == ST_DONE) begin
                        act_d = ACT_IDLE;
                    end else if (bus.pause_p || !bus.door_closed) begin
                        state_d = ST_HOLD;
                        act_d   = ACT_IDLE;
                    end
                end
                ST_HOLD: begin
                    act_d = ACT_IDLE;
                    if ((bus.start_p || bus.pause_p) && bus.door_closed) begin
                        state_d = ST_RUN;
                        act_d   = act_of(phase_q, s_q, pat_q);
                    end
                end
                ST_DONE: begin
                    phase_d  = PH_SPIN;
                    act_d    = ACT_IDLE;
                    remain_d = 7'd0;
                    if (bus.start_p) begin
                        state_d = ST_IDLE;
                        phase_d = PH_SETUP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.phase   = phase_q;
    assign bus.act     = act_q;
    assign bus.remain  = remain_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.buzz    = buzz_q;
endmodule
